// File: rtl/wishbone_decoder_if.sv
// Wishbone bus bundle between the arbitrated manager, the decoder and the
// NUM_SUBORDINATES downstream subordinates. Subordinate-side vectors are
// flat, with slice k belonging to subordinate k.
//
// Handshake: a manager request is valid while STB_I & CYC_I are high, and
// it is held stable until ACK_O is seen. ACK_O is a one-cycle completion
// strobe and DAT_O is valid only in that cycle. Toward each subordinate the
// same rule applies: S_STB_O/S_CYC_O are held until that subordinate raises
// S_ACK_I, or until the manager drops CYC_I to abort.
interface wishbone_decoder_if #(
  parameter int NUM_SUBORDINATES = 4
) ();
  // Manager side
  logic [31:0]                    ADR_I;
  logic [31:0]                    DAT_I;
  logic [3:0]                     SEL_I;
  logic                           WE_I;
  logic                           STB_I;
  logic                           CYC_I;
  logic [31:0]                    DAT_O;
  logic                           ACK_O;
  // Subordinate side
  logic [32*NUM_SUBORDINATES-1:0] S_ADR_O;
  logic [32*NUM_SUBORDINATES-1:0] S_DAT_O;
  logic [4*NUM_SUBORDINATES-1:0]  S_SEL_O;
  logic [NUM_SUBORDINATES-1:0]    S_WE_O;
  logic [NUM_SUBORDINATES-1:0]    S_STB_O;
  logic [NUM_SUBORDINATES-1:0]    S_CYC_O;
  logic [32*NUM_SUBORDINATES-1:0] S_DAT_I;
  logic [NUM_SUBORDINATES-1:0]    S_ACK_I;

  // Decoder view
  modport slave (
    input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    output DAT_O, ACK_O,
    output S_ADR_O, S_DAT_O, S_SEL_O, S_WE_O, S_STB_O, S_CYC_O,
    input  S_DAT_I, S_ACK_I
  );

  // Environment view: drives the manager request and the subordinate replies
  modport master (
    output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
    input  DAT_O, ACK_O,
    input  S_ADR_O, S_DAT_O, S_SEL_O, S_WE_O, S_STB_O, S_CYC_O,
    output S_DAT_I, S_ACK_I
  );
endinterface

// File: rtl/wishbone_decoder.sv
// Address decoder placed after the manager arbitrator. It latches the target
// subordinate at the start of a transaction, passes the bus through to that
// subordinate only, and terminates unmapped or hung accesses with an error
// ACK carrying ERR_DATA so the manager is never left waiting forever.
// Only one transaction is outstanding at a time.
module wishbone_decoder #(
  parameter int                             NUM_SUBORDINATES = 4,
  // Default bases cover NUM_SUBORDINATES = 4; override both together.
  parameter logic [32*NUM_SUBORDINATES-1:0] SUB_BASE = {32'h3003_0000, 32'h3002_0000,
                                                        32'h3001_0000, 32'h3000_0000},
  parameter logic [32*NUM_SUBORDINATES-1:0] SUB_MASK = {NUM_SUBORDINATES{32'hFFFF_0000}},
  parameter int                             TIMEOUT_CYCLES   = 255,
  parameter logic [31:0]                    ERR_DATA         = 32'hDEAD_BEEF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  wishbone_decoder_if.slave    bus,
  input  logic                 ERR_CLR,
  output logic                 BUS_ERR,
  output logic [31:0]          ERR_ADR,
  output logic [1:0]           o_dbg_state
);

  localparam int SW         = (NUM_SUBORDINATES > 1) ? $clog2(NUM_SUBORDINATES) : 1;
  // A zero TIMEOUT_CYCLES would give a zero-width counter; keep one bit.
  localparam int CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [SW-1:0] r_sel;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic          r_bus_err;
  logic [31:0]   r_err_adr;

  logic          w_req;
  logic          w_hit;
  logic [SW-1:0] w_hit_idx;
  logic          w_err_set;
  logic          w_sel_ack;
  logic [31:0]   w_sel_dat;

  logic [32*NUM_SUBORDINATES-1:0] w_s_adr;
  logic [32*NUM_SUBORDINATES-1:0] w_s_dat;
  logic [4*NUM_SUBORDINATES-1:0]  w_s_sel;
  logic [NUM_SUBORDINATES-1:0]    w_s_we;
  logic [NUM_SUBORDINATES-1:0]    w_s_stb;
  logic [NUM_SUBORDINATES-1:0]    w_s_cyc;
  logic [31:0]                    w_dat_o;
  logic                           w_ack_o;

  assign w_req = bus.STB_I & bus.CYC_I;

  // Address match; scanning from the top down leaves the lowest hit index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = NUM_SUBORDINATES - 1; k >= 0; k--) begin
      if ((bus.ADR_I & SUB_MASK[k*32 +: 32]) == SUB_BASE[k*32 +: 32]) begin
        w_hit     = 1'b1;
        w_hit_idx = SW'(k);
      end
    end
  end

  // Read data and acknowledge of the latched subordinate; others are ignored.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < NUM_SUBORDINATES; k++) begin
      if (SW'(k) == r_sel) begin
        w_sel_ack = bus.S_ACK_I[k];
        w_sel_dat = bus.S_DAT_I[k*32 +: 32];
      end
    end
  end

  // State, target select, timeout counter and error capture registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
      r_err_adr <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (r_state == ST_IDLE && w_req && w_hit) begin
        r_sel <= w_hit_idx;
      end
      if (w_err_set) begin
        r_err_adr <= bus.ADR_I;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_err_set) begin
        r_bus_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  // Next-state logic and bus steering for each state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_err_set    = 1'b0;
    w_s_adr      = '0;
    w_s_dat      = '0;
    w_s_sel      = '0;
    w_s_we       = '0;
    w_s_stb      = '0;
    w_s_cyc      = '0;
    w_dat_o      = '0;
    w_ack_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_next_state = ST_ACTIVE;
            w_next_cnt   = '0;
          end else begin
            w_next_state = ST_ERROR;
            w_err_set    = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!bus.CYC_I) begin
          // Manager abort: everything already defaults to 0 this cycle.
          w_next_state = ST_IDLE;
        end else begin
          for (int k = 0; k < NUM_SUBORDINATES; k++) begin
            if (SW'(k) == r_sel) begin
              w_s_adr[k*32 +: 32] = bus.ADR_I;
              w_s_dat[k*32 +: 32] = bus.DAT_I;
              w_s_sel[k*4 +: 4]   = bus.SEL_I;
              w_s_we[k]           = bus.WE_I;
              w_s_stb[k]          = bus.STB_I;
              w_s_cyc[k]          = bus.CYC_I;
            end
          end
          w_dat_o = w_sel_dat;
          w_ack_o = w_sel_ack;
          if (w_sel_ack) begin
            // An ACK on the threshold cycle still completes normally.
            w_next_state = ST_IDLE;
          end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST) begin
            w_next_state = ST_ERROR;
            w_err_set    = 1'b1;
          end else if (r_cnt != {CW{1'b1}}) begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_ERROR: begin
        w_ack_o      = 1'b1;
        w_dat_o      = ERR_DATA;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign bus.S_ADR_O = w_s_adr;
  assign bus.S_DAT_O = w_s_dat;
  assign bus.S_SEL_O = w_s_sel;
  assign bus.S_WE_O  = w_s_we;
  assign bus.S_STB_O = w_s_stb;
  assign bus.S_CYC_O = w_s_cyc;
  assign bus.DAT_O   = w_dat_o;
  assign bus.ACK_O   = w_ack_o;
  assign BUS_ERR     = r_bus_err;
  assign ERR_ADR     = r_err_adr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wishbone_decoder.sv
// Directed bench for wishbone_decoder. The stimulus thread pushes every
// expected manager ACK (cycle and data) into exp_q; an independent monitor
// pops and compares whenever ACK_O is seen. Routing, error flag and reset
// behaviour are checked inline by the stimulus thread.
module tb_wishbone_decoder;

  localparam int N = 4;
  localparam int W = 64;  // {expected cycle, expected DAT_O}

  logic        CLK;
  logic        nRST;
  logic        ERR_CLR;
  logic        BUS_ERR;
  logic [31:0] ERR_ADR;
  logic [1:0]  o_dbg_state;

  wishbone_decoder_if #(.NUM_SUBORDINATES(N)) bus ();

  wishbone_decoder dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus.slave),
    .ERR_CLR     (ERR_CLR),
    .BUS_ERR     (BUS_ERR),
    .ERR_ADR     (ERR_ADR),
    .o_dbg_state (o_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t required done", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.ADR_I = '0; bus.DAT_I = '0; bus.SEL_I = '0; bus.WE_I = 1'b0;
    bus.STB_I = 1'b0; bus.CYC_I = 1'b0;
    bus.S_ACK_I = '0; bus.S_DAT_I = '0;
  endtask

  // Advance one cycle and present a request; returns the request cycle.
  task automatic wb_req(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, output int n);
    tick();
    n = cyc;
    bus.ADR_I = adr; bus.DAT_I = dat; bus.SEL_I = sel; bus.WE_I = we;
    bus.STB_I = 1'b1; bus.CYC_I = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (nRST && bus.ACK_O) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {32'(cyc), bus.DAT_O}, 64'h0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(e[63:32]));
        chk("ack_data", 64'(bus.DAT_O), 64'(e[31:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int stb_cnt;
    nRST = 1'b0;
    ERR_CLR = 1'b0;
    idle_bus();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", 64'(o_dbg_state), 64'd0);
    chk("rst_ack", 64'(bus.ACK_O), 64'd0);
    chk("rst_dat", 64'(bus.DAT_O), 64'd0);
    chk("rst_s_stb", 64'(bus.S_STB_O), 64'd0);
    chk("rst_s_adr", 64'(bus.S_ADR_O[63:0]), 64'd0);
    chk("rst_bus_err", 64'(BUS_ERR), 64'd0);
    chk("rst_err_adr", 64'(ERR_ADR), 64'd0);
    nRST = 1'b1;
    tick();

    // Read from subordinate 1, ACK two cycles after STB.
    wb_req(32'h3001_0004, 32'h0, 4'hF, 1'b0, n);
    exp_q.push_back({32'(n + 3), 32'hA5A5_0001});
    @(negedge CLK);
    chk("rd_idle_no_stb", 64'(bus.S_STB_O), 64'd0);
    tick();
    bus.S_ACK_I = 4'b0001;  // stray ACK from a non-selected subordinate
    @(negedge CLK);
    chk("rd_stb", 64'(bus.S_STB_O), 64'h2);
    chk("rd_adr1", 64'(bus.S_ADR_O[63:32]), 64'h3001_0004);
    chk("rd_ignore_ack", 64'(bus.ACK_O), 64'd0);
    tick();
    bus.S_ACK_I = '0;
    tick();
    bus.S_DAT_I[63:32] = 32'hA5A5_0001;
    bus.S_ACK_I = 4'b0010;
    tick();
    idle_bus();
    @(negedge CLK);
    chk("rd_back_idle", 64'(o_dbg_state), 64'd0);

    // Write to subordinate 3, ACK on first ACTIVE cycle.
    wb_req(32'h3003_0010, 32'h1234_5678, 4'b0011, 1'b1, n);
    exp_q.push_back({32'(n + 1), 32'h0000_0000});
    tick();
    bus.S_ACK_I = 4'b1000;
    @(negedge CLK);
    chk("wr_adr3", 64'(bus.S_ADR_O[127:96]), 64'h3003_0010);
    chk("wr_dat3", 64'(bus.S_DAT_O[127:96]), 64'h1234_5678);
    chk("wr_sel3", 64'(bus.S_SEL_O[15:12]), 64'h3);
    chk("wr_we", 64'(bus.S_WE_O), 64'h8);
    chk("wr_stb", 64'(bus.S_STB_O), 64'h8);
    chk("wr_cyc", 64'(bus.S_CYC_O), 64'h8);
    chk("wr_others_adr", 64'(bus.S_ADR_O[95:0] != 96'd0), 64'd0);
    chk("wr_others_dat", 64'(bus.S_DAT_O[95:0] != 96'd0), 64'd0);
    chk("wr_others_sel", 64'(bus.S_SEL_O[11:0]), 64'd0);
    tick();
    idle_bus();

    // Unmapped access.
    wb_req(32'h4000_0000, 32'h0, 4'hF, 1'b0, n);
    exp_q.push_back({32'(n + 1), 32'hDEAD_BEEF});
    tick();
    @(negedge CLK);
    chk("unm_no_stb", 64'(bus.S_STB_O), 64'd0);
    chk("unm_bus_err", 64'(BUS_ERR), 64'd1);
    chk("unm_err_adr", 64'(ERR_ADR), 64'h4000_0000);
    tick();
    idle_bus();
    ERR_CLR = 1'b1;  // clear pulsed alone
    tick();
    ERR_CLR = 1'b0;
    @(negedge CLK);
    chk("clr_alone", 64'(BUS_ERR), 64'd0);
    chk("clr_keeps_adr", 64'(ERR_ADR), 64'h4000_0000);

    // Subordinate 2 never ACKs: 255 STB cycles, error ACK at N+256.
    wb_req(32'h3002_0000, 32'h0, 4'hF, 1'b0, n);
    exp_q.push_back({32'(n + 256), 32'hDEAD_BEEF});
    stb_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      @(negedge CLK);
      if (bus.S_STB_O[2]) stb_cnt++;
    end
    chk("to_stb_cycles", 64'(stb_cnt), 64'd255);
    chk("to_bus_err", 64'(BUS_ERR), 64'd1);
    chk("to_err_adr", 64'(ERR_ADR), 64'h3002_0000);
    tick();
    idle_bus();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;

    // Same subordinate ACKs on the threshold cycle: normal completion wins.
    wb_req(32'h3002_0008, 32'h0, 4'hF, 1'b0, n);
    for (int i = 0; i < 254; i++) tick();
    tick();
    exp_q.push_back({32'(n + 255), 32'h0000_2222});
    bus.S_DAT_I[95:64] = 32'h0000_2222;
    bus.S_ACK_I = 4'b0100;
    tick();
    idle_bus();
    @(negedge CLK);
    chk("to_ack_wins_err", 64'(BUS_ERR), 64'd0);
    chk("to_ack_wins_state", 64'(o_dbg_state), 64'd0);

    // Clear and new error in the same cycle: set wins; then clear alone.
    wb_req(32'h0000_1234, 32'h0, 4'hF, 1'b0, n);
    ERR_CLR = 1'b1;
    exp_q.push_back({32'(n + 1), 32'hDEAD_BEEF});
    tick();
    ERR_CLR = 1'b0;
    @(negedge CLK);
    chk("setclr_bus_err", 64'(BUS_ERR), 64'd1);
    chk("setclr_err_adr", 64'(ERR_ADR), 64'h0000_1234);
    tick();
    idle_bus();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    @(negedge CLK);
    chk("clr_after_set", 64'(BUS_ERR), 64'd0);

    // Manager abort mid-ACTIVE with a subordinate ACK present.
    wb_req(32'h3000_0008, 32'h0, 4'hF, 1'b0, n);
    tick();
    @(negedge CLK);
    chk("abort_stb_before", 64'(bus.S_STB_O), 64'h1);
    tick();
    bus.CYC_I = 1'b0;
    bus.S_ACK_I = 4'b0001;
    @(negedge CLK);
    chk("abort_stb", 64'(bus.S_STB_O), 64'd0);
    chk("abort_cyc", 64'(bus.S_CYC_O), 64'd0);
    chk("abort_ack", 64'(bus.ACK_O), 64'd0);
    tick();
    idle_bus();
    @(negedge CLK);
    chk("abort_idle", 64'(o_dbg_state), 64'd0);

    // Asynchronous reset mid-ACTIVE, then a normal access.
    wb_req(32'h3001_0000, 32'h0, 4'hF, 1'b0, n);
    tick();
    @(negedge CLK);
    chk("arst_stb_before", 64'(bus.S_STB_O), 64'h2);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_stb", 64'(bus.S_STB_O), 64'd0);
    chk("arst_cyc", 64'(bus.S_CYC_O), 64'd0);
    chk("arst_ack", 64'(bus.ACK_O), 64'd0);
    chk("arst_state", 64'(o_dbg_state), 64'd0);
    chk("arst_err_adr", 64'(ERR_ADR), 64'd0);
    idle_bus();
    tick();
    nRST = 1'b1;
    tick();
    wb_req(32'h3001_0000, 32'h0, 4'hF, 1'b0, n);
    exp_q.push_back({32'(n + 1), 32'h5555_AAAA});
    tick();
    bus.S_DAT_I[63:32] = 32'h5555_AAAA;
    bus.S_ACK_I = 4'b0010;
    tick();
    idle_bus();
    repeat (3) tick();

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
